// File: rtl/pcie_regfile_pkg.sv
// Shared types and helpers for the CPU-visible PCIe register file.
// Holds the read FSM encoding, the timeout fill pattern and the halfword-swap index map.
package pcie_regfile_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_EXT = 2'd1,
        RESP     = 2'd2
    } rd_state_t;

    localparam int MAX_DATA_WIDTH = 1024;

    // Data returned when an external source never answers; sliced to DATA_WIDTH.
    localparam logic [MAX_DATA_WIDTH-1:0] TIMEOUT_DATA = '1;

    // Source bit for output bit bit_idx when the upper and lower halves are swapped.
    function automatic int swap_index(input int bit_idx, input int width);
        return (bit_idx + width / 2) % width;
    endfunction

endpackage

// File: rtl/pcie_regfile.sv
// Parametrised CPU register file with RW, read-only and external-handshake channels.
// Optional build macro REGFILE_RDTIMEOUT_EN bounds the wait for an external source.
module pcie_regfile
    import pcie_regfile_pkg::*;
#(
    parameter int CHAN_WIDTH     = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int EN_SWAP        = 0,
    parameter logic [(2**CHAN_WIDTH)-1:0] RO_MASK  = '0,
    parameter logic [(2**CHAN_WIDTH)-1:0] EXT_MASK = '0,
    parameter logic [(2**CHAN_WIDTH)*DATA_WIDTH-1:0] RESET_VALS = '0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                   pcieClk_in,
    input  logic                                   pcieRstN_in,
    input  logic [CHAN_WIDTH-1:0]                  cpuChan_in,
    input  logic [DATA_WIDTH-1:0]                  cpuWrData_in,
    input  logic                                   cpuWrValid_in,
    output logic                                   cpuWrReady_out,
    output logic [DATA_WIDTH-1:0]                  cpuRdData_out,
    output logic                                   cpuRdValid_out,
    input  logic                                   cpuRdReady_in,
    output logic [(2**CHAN_WIDTH)*DATA_WIDTH-1:0]  regs_out,
    output logic [(2**CHAN_WIDTH)-1:0]             wrStrobe_out,
    input  logic [(2**CHAN_WIDTH)*DATA_WIDTH-1:0]  extData_in,
    input  logic [(2**CHAN_WIDTH)-1:0]             extValid_in,
    output logic [(2**CHAN_WIDTH)-1:0]             extAck_out,
    output logic                                   rdTimeout_out
);

    localparam int NUM_CHANS = 2**CHAN_WIDTH;

    if (EN_SWAP != 0 && (DATA_WIDTH % 2) != 0) begin : g_bad_swap_width
        $error("pcie_regfile: DATA_WIDTH must be even when EN_SWAP=1");
    end
    if (DATA_WIDTH > MAX_DATA_WIDTH || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("pcie_regfile: DATA_WIDTH or TIMEOUT_CYCLES out of range");
    end

    logic [DATA_WIDTH-1:0] regs      [NUM_CHANS];
    logic [DATA_WIDTH-1:0] ext_words [NUM_CHANS];
    rd_state_t             state, state_next;
    logic [CHAN_WIDTH-1:0] rd_chan;
    logic                  wr_ready, wr_fire, tmo_hit;
    logic [DATA_WIDTH-1:0] rd_src, rd_swapped, rd_fmt;

    for (genvar c = 0; c < NUM_CHANS; c++) begin : g_chan
        assign regs_out[c*DATA_WIDTH +: DATA_WIDTH] = regs[c];
        assign ext_words[c] = extData_in[c*DATA_WIDTH +: DATA_WIDTH];
    end

    assign wr_fire        = cpuWrValid_in & wr_ready;
    assign cpuWrReady_out = wr_ready;
    assign cpuRdValid_out = (state == RESP);

    // NOTE: every entry is reset to its own RESET_VALS slice, so software can read
    // defaults before any write; this rules out mapping the array onto a RAM macro.
    always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
        if (!pcieRstN_in) begin
            for (int c = 0; c < NUM_CHANS; c++) begin
                regs[c] <= RESET_VALS[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end else if (wr_fire && !RO_MASK[cpuChan_in] && !EXT_MASK[cpuChan_in]) begin
            regs[cpuChan_in] <= cpuWrData_in;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
        if (!pcieRstN_in) begin
            wr_ready     <= 1'b0;
            wrStrobe_out <= '0;
        end else begin
            wr_ready     <= 1'b1;
            wrStrobe_out <= '0;
            if (wr_fire) wrStrobe_out[cpuChan_in] <= 1'b1;
        end
    end

    // In IDLE the read source is the addressed register; afterwards it is the latched ext channel.
    assign rd_src = (state == IDLE) ? regs[cpuChan_in] : ext_words[rd_chan];

    for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_swap
        assign rd_swapped[b] = rd_src[swap_index(b, DATA_WIDTH)];
    end
    assign rd_fmt = (EN_SWAP != 0) ? rd_swapped : rd_src;

`ifdef REGFILE_RDTIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;

    assign tmo_hit = (state == WAIT_EXT) && !extValid_in[rd_chan]
                     && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
        if (!pcieRstN_in)            wait_cnt <= '0;
        else if (state == WAIT_EXT)  wait_cnt <= wait_cnt + 1'b1;
        else                         wait_cnt <= '0;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
        if (!pcieRstN_in) state <= IDLE;
        else              state <= state_next;
    end

    // NOTE: state_next gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (cpuRdReady_in) state_next = EXT_MASK[cpuChan_in] ? WAIT_EXT : RESP;
            WAIT_EXT: if (extValid_in[rd_chan] || tmo_hit) state_next = RESP;
            RESP:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Response data is loaded on the edge entering RESP and held until the next response.
    always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
        if (!pcieRstN_in) begin
            rd_chan       <= '0;
            cpuRdData_out <= '0;
            extAck_out    <= '0;
            rdTimeout_out <= 1'b0;
        end else begin
            extAck_out    <= '0;
            rdTimeout_out <= 1'b0;
            case (state)
                IDLE: if (cpuRdReady_in) begin
                    rd_chan <= cpuChan_in;
                    if (!EXT_MASK[cpuChan_in]) cpuRdData_out <= rd_fmt;
                end
                WAIT_EXT: if (extValid_in[rd_chan]) begin
                    cpuRdData_out       <= rd_fmt;
                    extAck_out[rd_chan] <= 1'b1;
                end else if (tmo_hit) begin
                    cpuRdData_out <= TIMEOUT_DATA[DATA_WIDTH-1:0];
                    rdTimeout_out <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
